// File: rtl/grid_display_pkg.sv
// ============================================================================
// Module      : grid_display_pkg
// Description : Shared colours, axis-class and error-FSM encodings, and a
//               width helper for the grid_display pixel renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package grid_display_pkg;

    localparam int RGB_W = 12;

    localparam logic [RGB_W-1:0] GAP_COLOR      = 12'h7FF;
    localparam logic [RGB_W-1:0] BORDER_DEFAULT = 12'h606;
    localparam logic [RGB_W-1:0] BORDER_ERROR   = 12'hA30;

    // Where a scan coordinate falls along one axis of the board
    typedef enum logic [1:0] {
        BORDER = 2'd0,
        GAP    = 2'd1,
        CELL   = 2'd2
    } axis_class_t;

    // Error-display state machine
    typedef enum logic {
        IDLE = 1'b0,
        ERR  = 1'b1
    } err_state_t;

    // $clog2 that never yields a zero-width vector
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/grid_axis_decode.sv
// ============================================================================
// Module      : grid_axis_decode
// Description : Classifies one scan coordinate as border, gap or cell and
//               returns the cell index, using constant comparators only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_axis_decode
    import grid_display_pkg::*;
#(
    parameter int ORIGIN = 110,
    parameter int N      = 4,
    parameter int CELL_W = 100,
    parameter int GAP_W  = 4,
    localparam int IDX_W = idx_width(N)
) (
    input  logic [9:0]       pos,
    output axis_class_t      cls,
    output logic [IDX_W-1:0] idx
);

    // Last coordinate belonging to the grid (closing gap line included)
    localparam int LAST = ORIGIN + (N + 1) * GAP_W + N * CELL_W;

    int w_pos;
    assign w_pos = int'(pos);

    // Cell i spans (ORIGIN+(i+1)*GAP_W+i*CELL_W, ORIGIN+(i+1)*(GAP_W+CELL_W)];
    // the ranges are disjoint, so no priority is implied by the loop order.
    always_comb begin
        cls = GAP;
        idx = '0;
        if (w_pos <= ORIGIN || w_pos > LAST) begin
            cls = BORDER;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_pos >  ORIGIN + (i + 1) * GAP_W + i * CELL_W &&
                    w_pos <= ORIGIN + (i + 1) * (GAP_W + CELL_W)) begin
                    cls = CELL;
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/grid_display.sv
// ============================================================================
// Module      : grid_display
// Description : Two-stage pixel renderer for a ROWS x COLS tile grid with gap
//               lines, a border, and an error-hold / blinking border.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_display
    import grid_display_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int CELL_W          = 100,
    parameter int GAP_W           = 4,
    parameter int ORIGIN_X        = 110,
    parameter int ORIGIN_Y        = 30,
    parameter int ERR_HOLD_FRAMES = 60,
    parameter int BLINK_FRAMES    = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [9:0]                  x,
    input  logic [9:0]                  y,
    input  logic                        videoOn,
    input  logic [ROWS*COLS*RGB_W-1:0]  cells,
    input  logic                        error,
    output logic [RGB_W-1:0]            rgb
);

    localparam int XI_W    = idx_width(COLS);
    localparam int YI_W    = idx_width(ROWS);
    localparam int CELL_N  = ROWS * COLS;
    localparam int FLAT_W  = idx_width(CELL_N);
    localparam int HOLD_W  = idx_width(ERR_HOLD_FRAMES + 1);
    localparam int BLINK_W = idx_width(BLINK_FRAMES);

    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(ERR_HOLD_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    axis_class_t       w_x_cls, w_y_cls;
    logic [XI_W-1:0]   w_x_idx;
    logic [YI_W-1:0]   w_y_idx;
    logic              w_pos_nonzero;

    axis_class_t       r_x_cls, r_y_cls;
    logic [XI_W-1:0]   r_x_idx;
    logic [YI_W-1:0]   r_y_idx;
    logic              r_video;
    logic              r_valid;
    logic              r_pos_nonzero;
    logic              r_frame_start;

    err_state_t        r_state;
    logic [HOLD_W-1:0] r_hold;
    logic [BLINK_W-1:0] r_blink;
    logic              r_phase;

    logic [RGB_W-1:0]  w_border;
    logic [FLAT_W-1:0] w_flat;
    logic [RGB_W-1:0]  w_cell_color [CELL_N];

    grid_axis_decode #(
        .ORIGIN (ORIGIN_X),
        .N      (COLS),
        .CELL_W (CELL_W),
        .GAP_W  (GAP_W)
    ) u_x_decode (
        .pos (x),
        .cls (w_x_cls),
        .idx (w_x_idx)
    );

    grid_axis_decode #(
        .ORIGIN (ORIGIN_Y),
        .N      (ROWS),
        .CELL_W (CELL_W),
        .GAP_W  (GAP_W)
    ) u_y_decode (
        .pos (y),
        .cls (w_y_cls),
        .idx (w_y_idx)
    );

    assign w_pos_nonzero = (x != 10'd0) || (y != 10'd0);

    // Stage 1: register axis decode, video flag, and the frame-start edge of (0,0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x_cls       <= BORDER;
            r_y_cls       <= BORDER;
            r_x_idx       <= '0;
            r_y_idx       <= '0;
            r_video       <= 1'b0;
            r_valid       <= 1'b0;
            r_pos_nonzero <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_x_cls       <= w_x_cls;
            r_y_cls       <= w_y_cls;
            r_x_idx       <= w_x_idx;
            r_y_idx       <= w_y_idx;
            r_video       <= videoOn;
            r_valid       <= 1'b1;
            r_pos_nonzero <= w_pos_nonzero;
            r_frame_start <= r_pos_nonzero && !w_pos_nonzero;
        end
    end

    // Error FSM: hold timer reloads while error is high, blink phase toggles every BLINK_FRAMES frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_blink <= '0;
            r_phase <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (error) begin
                        r_state <= ERR;
                        r_hold  <= HOLD_LOAD;
                        r_blink <= '0;
                        r_phase <= 1'b0;
                    end
                end
                ERR: begin
                    if (error) begin
                        r_hold <= HOLD_LOAD;
                    end else if (r_frame_start && r_hold != '0) begin
                        r_hold <= r_hold - 1'b1;
                    end
                    if (r_frame_start) begin
                        if (r_blink == BLINK_LAST) begin
                            r_blink <= '0;
                            r_phase <= ~r_phase;
                        end else begin
                            r_blink <= r_blink + 1'b1;
                        end
                    end
                    if (r_hold == '0 && !error) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Flatten the cell bus into an addressable table
    for (genvar g = 0; g < CELL_N; g++) begin : g_cell_unpack
        assign w_cell_color[g] = cells[g*RGB_W +: RGB_W];
    end

    // Border colour and row-major cell address for the pixel held in stage 1
    always_comb begin
        w_border = (r_state == ERR && !r_phase) ? BORDER_ERROR : BORDER_DEFAULT;
        w_flat   = FLAT_W'(r_y_idx) * FLAT_W'(COLS) + FLAT_W'(r_x_idx);
    end

    // Stage 2: pick the pixel colour
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb <= '0;
        end else if (!(r_valid && r_video)) begin
            rgb <= '0;
        end else if (r_x_cls == BORDER || r_y_cls == BORDER) begin
            rgb <= w_border;
        end else if (r_x_cls == CELL && r_y_cls == CELL) begin
            rgb <= w_cell_color[w_flat];
        end else begin
            rgb <= GAP_COLOR;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_grid_display.sv
// ============================================================================
// Module      : tb_grid_display
// Description : Self-checking bench for grid_display: three instances
//               (default, short hold/blink, small 3x5 grid) compared against
//               an arithmetic geometry model and a frame-level error model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_grid_display;

    logic         clk = 1'b0;
    logic         reset;
    logic [9:0]   x, y;
    logic         videoOn;
    logic         error;
    logic [191:0] cells_a;
    logic [179:0] cells_s;
    logic [11:0]  rgb_a, rgb_e, rgb_s;

    int checks = 0;
    int errors = 0;

    // frame-level error model, one entry per DUT (0=a, 1=e, 2=s)
    int in_err    [3];
    int hold_left [3];
    int frames_in [3];
    int hold_p    [3] = '{60, 6, 60};
    int blink_p   [3] = '{15, 2, 15};

    // pixel history (the pixel whose colour appears after the next edge)
    int   hx, hy;
    logic hv;
    logic prev_nz;

    always #5 clk = ~clk;

    grid_display dut_a (
        .clk(clk), .reset(reset), .x(x), .y(y), .videoOn(videoOn),
        .cells(cells_a), .error(error), .rgb(rgb_a)
    );

    grid_display #(.ERR_HOLD_FRAMES(6), .BLINK_FRAMES(2)) dut_e (
        .clk(clk), .reset(reset), .x(x), .y(y), .videoOn(videoOn),
        .cells(cells_a), .error(error), .rgb(rgb_e)
    );

    grid_display #(.ROWS(3), .COLS(5), .CELL_W(20), .GAP_W(2),
                   .ORIGIN_X(0), .ORIGIN_Y(0)) dut_s (
        .clk(clk), .reset(reset), .x(x), .y(y), .videoOn(videoOn),
        .cells(cells_s), .error(error), .rgb(rgb_s)
    );

    // -2 border, -1 gap, otherwise cell index; cells repeat with period gw+cw
    function automatic int ref_axis(input int p, input int o, input int n,
                                    input int cw, input int gw);
        int q;
        if (p <= o || p > o + (n + 1) * gw + n * cw) return -2;
        q = p - o - 1;
        if ((q % (gw + cw)) < gw) return -1;
        return q / (gw + cw);
    endfunction

    function automatic logic [11:0] ref_border(input int d);
        if (in_err[d] != 0 && ((frames_in[d] / blink_p[d]) % 2) == 0) return 12'hA30;
        return 12'h606;
    endfunction

    function automatic logic [11:0] ref_pix(input int d, input int px, input int py,
                                            input logic vid, input logic [191:0] cv);
        int ax, ay, cols;
        if (d == 2) begin
            ax = ref_axis(px, 0, 5, 20, 2);
            ay = ref_axis(py, 0, 3, 20, 2);
            cols = 5;
        end else begin
            ax = ref_axis(px, 110, 4, 100, 4);
            ay = ref_axis(py, 30, 4, 100, 4);
            cols = 4;
        end
        if (!vid) return 12'h000;
        if (ax == -2 || ay == -2) return ref_border(d);
        if (ax >= 0 && ay >= 0) return cv[(ay * cols + ax) * 12 +: 12];
        return 12'h7FF;
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            in_err[d] = 0; hold_left[d] = 0; frames_in[d] = 0;
        end
        hv = 1'b0;
        prev_nz = 1'b0;
    endtask

    task automatic model_error_rise();
        for (int d = 0; d < 3; d++) begin
            if (in_err[d] == 0) begin
                in_err[d] = 1; frames_in[d] = 0;
            end
            hold_left[d] = hold_p[d];
        end
    endtask

    task automatic model_frame_start();
        for (int d = 0; d < 3; d++) begin
            if (in_err[d] != 0) begin
                frames_in[d]++;
                if (!error) begin
                    if (hold_left[d] > 0) hold_left[d]--;
                    if (hold_left[d] == 0) in_err[d] = 0;
                end
            end
        end
    endtask

    // Drive one pixel for one clock; optionally check the colour of the previous pixel
    task automatic step(input int px, input int py, input logic vid, input logic chk, input string tag);
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        x = px[9:0];
        y = py[9:0];
        videoOn = vid;
        cells_a = r;
        cells_s = r[179:0];
        if (px == 0 && py == 0 && prev_nz) model_frame_start();
        prev_nz = !(px == 0 && py == 0);
        @(posedge clk);
        @(negedge clk);
        if (chk) begin
            check({tag, "/a"}, rgb_a, ref_pix(0, hx, hy, hv, cells_a));
            check({tag, "/e"}, rgb_e, ref_pix(1, hx, hy, hv, cells_a));
            check({tag, "/s"}, rgb_s, ref_pix(2, hx, hy, hv, {12'h000, cells_s}));
        end
        hx = px; hy = py; hv = vid;
    endtask

    // One short frame: frame start at (0,0), then settle on a border pixel and check
    task automatic frame(input string tag);
        step(0, 0, 1'b1, 1'b0, tag);
        for (int k = 0; k < 3; k++) step(600, 5, 1'b1, 1'b0, tag);
        step(600, 5, 1'b1, 1'b1, tag);
    endtask

    int dir_x [] = '{112, 113, 114, 115, 120, 214, 215, 218, 219, 224, 318, 530, 531,
                     120, 120, 120, 120, 120, 120, 300, 23, 25, 113, 112, 22, 2, 3};
    int dir_y [] = '{40, 40, 40, 40, 40, 40, 40, 40, 40, 40, 40, 40, 40,
                     134, 135, 138, 139, 30, 31, 200, 1, 3, 1, 5, 22, 3, 23};

    initial begin
        reset = 1'b1;
        x = '0; y = '0; videoOn = 1'b0; error = 1'b0;
        cells_a = '0; cells_s = '0;
        model_reset();
        hx = 0; hy = 0;
        @(negedge clk);
        @(negedge clk);
        check("reset/a", rgb_a, 12'h000);
        check("reset/e", rgb_e, 12'h000);
        check("reset/s", rgb_s, 12'h000);
        reset = 1'b0;

        // directed geometry points, one new pixel per clock
        step(600, 600, 1'b1, 1'b0, "prime");
        foreach (dir_x[i]) step(dir_x[i], dir_y[i], 1'b1, 1'b1, $sformatf("dir%0d", i));
        step(120, 40, 1'b0, 1'b1, "vid0_a");
        step(224, 139, 1'b0, 1'b1, "vid0_b");
        step(224, 139, 1'b1, 1'b1, "vid0_c");

        // random pixels over the large grid, then concentrated on the small grid
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 640), $urandom_range(0, 520), $urandom_range(0, 7) != 0,
                 1'b1, $sformatf("rndL%0d", i));
        for (int i = 0; i < 150; i++)
            step($urandom_range(0, 120), $urandom_range(0, 75), $urandom_range(0, 7) != 0,
                 1'b1, $sformatf("rndS%0d", i));

        // asynchronous reset in the middle of a line
        step(120, 40, 1'b1, 1'b1, "pre_rst");
        #2 reset = 1'b1;
        #1;
        check("rst_mid/a", rgb_a, 12'h000);
        check("rst_mid/e", rgb_e, 12'h000);
        check("rst_mid/s", rgb_s, 12'h000);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(120, 40, 1'b1, 1'b1, "rst_rel1");
        step(224, 40, 1'b1, 1'b1, "rst_rel2");
        step(25, 3, 1'b1, 1'b1, "rst_rel3");

        // one-clock error pulse, then frames through the blink and hold periods
        step(600, 5, 1'b1, 1'b0, "pre_err");
        error = 1'b1;
        model_error_rise();
        step(600, 5, 1'b1, 1'b0, "err_pulse");
        error = 1'b0;
        for (int k = 0; k < 3; k++) step(600, 5, 1'b1, 1'b0, "settle");
        step(600, 5, 1'b1, 1'b1, "frame0");
        for (int f = 1; f <= 7; f++) frame($sformatf("pulse_frame%0d", f));

        // a fresh pulse restarts the blink at phase 0 only if the FSM went idle
        error = 1'b1;
        model_error_rise();
        step(600, 5, 1'b1, 1'b0, "repulse");
        for (int k = 0; k < 3; k++) step(600, 5, 1'b1, 1'b0, "settle");
        step(600, 5, 1'b1, 1'b1, "repulse_chk");

        // error held through 100 frames, then released
        for (int f = 0; f < 100; f++) frame($sformatf("held%0d", f));
        error = 1'b0;
        step(600, 5, 1'b1, 1'b0, "err_drop");
        for (int f = 1; f <= 64; f++) frame($sformatf("release%0d", f));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
